// File: rtl/dll_ctrl_pkg.sv
// Shared types and constants for the FMDLL lock controller.
package dll_ctrl_pkg;

   localparam logic [9:0] CODE_MID = 10'h200;

   // Signed phase-detector value: +1 lead, 0 no decision, -1 lag
   localparam int unsigned          PD_W    = 2;
   localparam logic signed [PD_W-1:0] PD_UP   = 2'sb01;
   localparam logic signed [PD_W-1:0] PD_NONE = 2'sb00;
   localparam logic signed [PD_W-1:0] PD_DN   = 2'sb11;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SAR_INIT   = 3'd1,
      SAR_SETTLE = 3'd2,
      SAR_STEP   = 3'd3,
      SAR_WAIT   = 3'd4,
      TRK_SETTLE = 3'd5,
      TRK_ACC    = 3'd6,
      TRK_UPD    = 3'd7
   } state_t;

   // Lead-only or lag-only gives a decision; both or neither gives none
   function automatic logic signed [PD_W-1:0] pd_decode(input logic lead, input logic lag);
      logic signed [PD_W-1:0] v;
      v = PD_NONE;
      if (lead && !lag)      v = PD_UP;
      else if (lag && !lead) v = PD_DN;
      return v;
   endfunction

endpackage

// File: rtl/dll_trk_filter.sv
// Tracking filter: PD accumulator, up/down decision, quiet/run lock bookkeeping.
// step_up/step_dn/quiet/lost are combinational and only meaningful while upd=1.
module dll_trk_filter
   import dll_ctrl_pkg::*;
#(
   parameter int unsigned TRACK_AVG  = 8,
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_RUN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   acc_en,
   input  logic                   upd,
   input  logic                   frz,
   input  logic signed [PD_W-1:0] pd,
   input  logic                   at_max,
   input  logic                   at_min,
   output logic                   step_up,
   output logic                   step_dn,
   output logic                   quiet,
   output logic                   lost
);

   localparam int unsigned ACC_W  = $clog2(TRACK_AVG) + 2;
   localparam int unsigned QCNT_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned RCNT_W = $clog2(UNLOCK_RUN + 1);
   localparam logic signed [ACC_W-1:0] THR = ACC_W'(TRACK_AVG / 2);

   logic signed [ACC_W-1:0] acc;
   logic [QCNT_W-1:0]       qcnt, qcnt_nx;
   logic [RCNT_W-1:0]       rcnt, rcnt_nx;
   logic                    last_up, last_dn;
   logic                    live, up_req, dn_req, sat, same_dir;

   // Decision and counter next values; a step with no prior step cannot extend a run
   always_comb begin
      live     = upd && !frz;
      up_req   = (acc >= THR);
      dn_req   = (acc <= -THR);
      sat      = (up_req && at_max) || (dn_req && at_min);
      step_up  = live && up_req && !at_max;
      step_dn  = live && dn_req && !at_min;
      same_dir = (step_up && last_up) || (step_dn && last_dn);
      qcnt_nx  = qcnt;
      rcnt_nx  = rcnt;
      if (same_dir) begin
         rcnt_nx = rcnt + RCNT_W'(1);
         qcnt_nx = '0;
      end else begin
         qcnt_nx = (qcnt == QCNT_W'(LOCK_CNT)) ? qcnt : qcnt + QCNT_W'(1);
         rcnt_nx = '0;
      end
      lost  = live && (sat || (same_dir && (rcnt_nx == RCNT_W'(UNLOCK_RUN))));
      quiet = live && !lost && (qcnt_nx == QCNT_W'(LOCK_CNT));
   end

   // Accumulator, counters and last step direction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         qcnt    <= '0;
         rcnt    <= '0;
         last_up <= 1'b0;
         last_dn <= 1'b0;
      end else if (clr || lost) begin
         acc     <= '0;
         qcnt    <= '0;
         rcnt    <= '0;
         last_up <= 1'b0;
         last_dn <= 1'b0;
      end else begin
         if (frz || upd)  acc <= '0;
         else if (acc_en) acc <= acc + ACC_W'(pd);
         if (live) begin
            qcnt <= qcnt_nx;
            rcnt <= rcnt_nx;
            if (step_up || step_dn) begin
               last_up <= step_up;
               last_dn <= step_dn;
            end
         end
      end
   end

endmodule

// File: rtl/dll_lock_ctrl.sv
// FMDLL lock sequencer: paces the 10-bit SAR search, then runs the filtered
// up/down tracking loop with lock / loss-of-lock detection.
// Optional macro DLL_TRACK_FREEZE_EN adds a 'freeze' input that pauses tracking.
module dll_lock_ctrl
   import dll_ctrl_pkg::*;
#(
   parameter int unsigned CODE_W     = 10,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned TRACK_AVG  = 8,
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_RUN = 4
) (
   input  logic              clk4,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              pd_lead,
   input  logic              pd_lag,
   input  logic [CODE_W-1:0] sar_q,
   input  logic [3:0]        sar_count,
`ifdef DLL_TRACK_FREEZE_EN
   input  logic              freeze,
`endif
   output logic              sar_rst_n,
   output logic              sar_step,
   output logic              sar_comp,
   output logic [CODE_W-1:0] dly_code,
   output logic              locked,
   output logic [7:0]        relock_cnt,
   output logic [2:0]        state
);

   localparam int unsigned CNT_MAX = (SETTLE_CYC > TRACK_AVG) ? SETTLE_CYC : TRACK_AVG;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   last_q, last_d;
   logic [CODE_W-1:0]      trk_code_q, trk_code_d, dly_code_d;
   logic                   sar_rst_n_d, sar_step_d, sar_comp_d, locked_d;
   logic [7:0]             relock_d;
   logic signed [PD_W-1:0] pd;
   logic                   frz, step_up, step_dn, quiet, lost;

   assign pd    = pd_decode(pd_lead, pd_lag);
   assign state = state_q;

`ifdef DLL_TRACK_FREEZE_EN
   assign frz = freeze && (state_q inside {TRK_SETTLE, TRK_ACC, TRK_UPD});
`else
   assign frz = 1'b0;
`endif

   dll_trk_filter #(
      .TRACK_AVG  (TRACK_AVG),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_RUN (UNLOCK_RUN)
   ) u_filt (
      .clk     (clk4),
      .rst_n   (rst_n),
      .clr     (state_q == IDLE),
      .acc_en  (state_q == TRK_ACC),
      .upd     (state_q == TRK_UPD),
      .frz     (frz),
      .pd      (pd),
      .at_max  (trk_code_q == '1),
      .at_min  (trk_code_q == '0),
      .step_up (step_up),
      .step_dn (step_dn),
      .quiet   (quiet),
      .lost    (lost)
   );

   // Next state plus output values, registered against the state they belong to
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      trk_code_d = trk_code_q;
      locked_d   = locked;
      relock_d   = relock_cnt;
      sar_comp_d = sar_comp;
      case (state_q)
         IDLE: if (enable) state_d = SAR_INIT;
         SAR_INIT: begin
            cnt_d   = CNT_W'(SETTLE_CYC);
            state_d = SAR_SETTLE;
         end
         SAR_SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = SAR_STEP;
         end
         SAR_STEP: begin
            last_d  = (sar_count == 4'd0);
            state_d = SAR_WAIT;
         end
         SAR_WAIT: begin
            cnt_d = CNT_W'(SETTLE_CYC);
            if (last_q) begin
               trk_code_d = sar_q;
               state_d    = TRK_SETTLE;
            end else begin
               state_d = SAR_SETTLE;
            end
         end
         TRK_SETTLE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = CNT_W'(TRACK_AVG);
               state_d = TRK_ACC;
            end
         end
         TRK_ACC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = TRK_UPD;
         end
         TRK_UPD: begin
            cnt_d   = CNT_W'(SETTLE_CYC);
            state_d = TRK_SETTLE;
            if (step_up)      trk_code_d = trk_code_q + CODE_W'(1);
            else if (step_dn) trk_code_d = trk_code_q - CODE_W'(1);
            if (quiet) locked_d = 1'b1;
            // Loss of lock passes through IDLE for the one-cycle SAR reset
            if (lost) begin
               locked_d = 1'b0;
               relock_d = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d  = IDLE;
         locked_d = 1'b0;
      end

      sar_rst_n_d = (state_d != IDLE);
      sar_step_d  = (state_d == SAR_STEP);
      if (sar_step_d && (pd != PD_NONE)) sar_comp_d = (pd == PD_UP);
      case (state_d)
         IDLE:                         dly_code_d = CODE_W'(CODE_MID);
         SAR_SETTLE:                   dly_code_d = sar_q;
         TRK_SETTLE, TRK_ACC, TRK_UPD: dly_code_d = trk_code_d;
         default:                      dly_code_d = dly_code;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk4 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b0;
         trk_code_q <= '0;
         sar_rst_n  <= 1'b0;
         sar_step   <= 1'b0;
         sar_comp   <= 1'b0;
         dly_code   <= CODE_W'(CODE_MID);
         locked     <= 1'b0;
         relock_cnt <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         trk_code_q <= trk_code_d;
         sar_rst_n  <= sar_rst_n_d;
         sar_step   <= sar_step_d;
         sar_comp   <= sar_comp_d;
         dly_code   <= dly_code_d;
         locked     <= locked_d;
         relock_cnt <= relock_d;
      end
   end

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl with a behavioural SAR and phase detector.
// Define DLL_TRACK_FREEZE_EN to also exercise the freeze input.
module tb_dll_lock_ctrl;
   import dll_ctrl_pkg::*;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned SEARCH_CYC = 1 + 10 * (SETTLE + 2) + 1;

   logic       clk4 = 1'b0;
   logic       rst_n, enable, pd_lead, pd_lag;
   logic [9:0] sar_q;
   logic [3:0] sar_count;
   logic       sar_rst_n, sar_step, sar_comp, locked;
   logic [9:0] dly_code;
   logic [7:0] relock_cnt;
   logic [2:0] state;
`ifdef DLL_TRACK_FREEZE_EN
   logic       freeze;
`endif

   int vecs = 0;
   int errs = 0;

   logic       pd_auto, f_lead, f_lag;
   logic [9:0] target;
   int         steps, cyc;
   logic [9:0] pat;

   always #5 clk4 = ~clk4;

   // Phase detector: comparator against target during search, forced otherwise
   assign pd_lead = pd_auto ? (dly_code <= target) : f_lead;
   assign pd_lag  = pd_auto ? (dly_code >  target) : f_lag;

   // Behavioural SAR: keep/clear current bit from sar_comp, then trial the next
   always @(posedge clk4 or negedge sar_rst_n) begin
      if (!sar_rst_n) begin
         sar_q     <= 10'h200;
         sar_count <= 4'd9;
      end else if (sar_step) begin
         sar_q[sar_count] <= sar_comp;
         if (sar_count != 4'd0) begin
            sar_q[sar_count - 4'd1] <= 1'b1;
            sar_count <= sar_count - 4'd1;
         end
      end
   end

   dll_lock_ctrl dut (
      .clk4       (clk4),
      .rst_n      (rst_n),
      .enable     (enable),
      .pd_lead    (pd_lead),
      .pd_lag     (pd_lag),
      .sar_q      (sar_q),
      .sar_count  (sar_count),
`ifdef DLL_TRACK_FREEZE_EN
      .freeze     (freeze),
`endif
      .sar_rst_n  (sar_rst_n),
      .sar_step   (sar_step),
      .sar_comp   (sar_comp),
      .dly_code   (dly_code),
      .locked     (locked),
      .relock_cnt (relock_cnt),
      .state      (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk4);
         n++;
      end
      chk(tag, 32'(state === s), 32'd1);
   endtask

   // Count sar_step pulses and collect sar_comp until tracking starts
   task automatic run_search(input int stop_at, output int n_step, output logic [9:0] p, output int n_cyc);
      n_step = 0;
      p      = '0;
      n_cyc  = 0;
      while (state !== 3'(TRK_SETTLE) && n_cyc < 200) begin
         @(negedge clk4);
         n_cyc++;
         if (sar_step) begin
            n_step++;
            p = {p[8:0], sar_comp};
            if (n_step == stop_at) return;
         end
      end
   endtask

   // Three windows of alternating lead/lag around the found code; ends with lag applied
   task automatic track_lock();
      logic [31:0] exp_code [3];
      exp_code[0] = 32'h2C6;
      exp_code[1] = 32'h2C5;
      exp_code[2] = 32'h2C6;
      pd_auto = 1'b0;
      f_lead  = 1'b1;
      f_lag   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_state(3'(TRK_UPD), 40, "alt_upd_reached");
         f_lead = ~f_lead;
         f_lag  = ~f_lag;
         @(negedge clk4);
         chk("alt_dly_code", 32'(dly_code), exp_code[k]);
         chk("alt_locked", 32'(locked), (k == 2) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      rst_n   = 1'b1;
      enable  = 1'b0;
      pd_auto = 1'b1;
      f_lead  = 1'b0;
      f_lag   = 1'b0;
      target  = 10'h2C5;
`ifdef DLL_TRACK_FREEZE_EN
      freeze  = 1'b0;
`endif
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk4);
      chk("rst_state",      32'(state),      32'(IDLE));
      chk("rst_sar_rst_n",  32'(sar_rst_n),  32'd0);
      chk("rst_sar_step",   32'(sar_step),   32'd0);
      chk("rst_sar_comp",   32'(sar_comp),   32'd0);
      chk("rst_dly_code",   32'(dly_code),   32'h200);
      chk("rst_locked",     32'(locked),     32'd0);
      chk("rst_relock_cnt", 32'(relock_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk4);

      // Search toward 0x2C5
      enable = 1'b1;
      run_search(0, steps, pat, cyc);
      chk("srch_state",    32'(state),    32'(TRK_SETTLE));
      chk("srch_steps",    32'(steps),    32'd10);
      chk("srch_pattern",  32'(pat),      32'b1011000101);
      chk("srch_latency",  32'(cyc),      32'(SEARCH_CYC));
      chk("srch_dly_code", 32'(dly_code), 32'h2C5);
      chk("srch_locked",   32'(locked),   32'd0);

      // Alternating PD windows reach lock
      track_lock();

      // Constant lag: one reversing step, then a same-direction run
      for (int j = 0; j < 4; j++) begin
         wait_state(3'(TRK_UPD), 40, "lag_upd_reached");
         @(negedge clk4);
         chk("lag_dly_code", 32'(dly_code), 32'h2C5 - 32'(j));
         chk("lag_locked",   32'(locked),   32'd1);
      end
      wait_state(3'(TRK_UPD), 40, "loss_upd_reached");
      @(negedge clk4);
      chk("loss_state",      32'(state),      32'(IDLE));
      chk("loss_locked",     32'(locked),     32'd0);
      chk("loss_relock_cnt", 32'(relock_cnt), 32'd1);
      chk("loss_sar_rst_n",  32'(sar_rst_n),  32'd0);
      chk("loss_dly_code",   32'(dly_code),   32'h200);
      target  = 10'h3FF;
      pd_auto = 1'b1;
      @(negedge clk4);
      chk("restart_state",     32'(state),     32'(SAR_INIT));
      chk("restart_sar_rst_n", 32'(sar_rst_n), 32'd1);

      // Search ends at the top code; constant lead must not wrap
      run_search(0, steps, pat, cyc);
      chk("top_steps",    32'(steps),    32'd10);
      chk("top_pattern",  32'(pat),      32'h3FF);
      chk("top_dly_code", 32'(dly_code), 32'h3FF);
      pd_auto = 1'b0;
      f_lead  = 1'b1;
      f_lag   = 1'b0;
      wait_state(3'(TRK_UPD), 40, "sat_upd_reached");
      chk("sat_dly_hold", 32'(dly_code), 32'h3FF);
      @(negedge clk4);
      chk("sat_state",      32'(state),      32'(IDLE));
      chk("sat_dly_code",   32'(dly_code),   32'h200);
      chk("sat_relock_cnt", 32'(relock_cnt), 32'd2);
      chk("sat_locked",     32'(locked),     32'd0);

      // Drop enable during the 5th SAR step
      target  = 10'h2C5;
      pd_auto = 1'b1;
      run_search(5, steps, pat, cyc);
      chk("drop_at_step",  32'(state), 32'(SAR_STEP));
      chk("drop_steps",    32'(steps), 32'd5);
      chk("drop_pattern",  32'(pat),   32'b10110);
      enable = 1'b0;
      @(negedge clk4);
      chk("drop_state",      32'(state),      32'(IDLE));
      chk("drop_dly_code",   32'(dly_code),   32'h200);
      chk("drop_locked",     32'(locked),     32'd0);
      chk("drop_relock_cnt", 32'(relock_cnt), 32'd2);
      chk("drop_sar_rst_n",  32'(sar_rst_n),  32'd0);
      repeat (3) @(negedge clk4);
      chk("drop_idle_hold", 32'(state), 32'(IDLE));

      // Re-enable: full search again
      enable = 1'b1;
      run_search(0, steps, pat, cyc);
      chk("re_steps",    32'(steps),    32'd10);
      chk("re_pattern",  32'(pat),      32'b1011000101);
      chk("re_latency",  32'(cyc),      32'(SEARCH_CYC));
      chk("re_dly_code", 32'(dly_code), 32'h2C5);

`ifdef DLL_TRACK_FREEZE_EN
      // Freeze while locked under constant lag
      track_lock();
      freeze = 1'b1;
      repeat (64) @(negedge clk4);
      chk("frz_dly_code",   32'(dly_code),   32'h2C6);
      chk("frz_locked",     32'(locked),     32'd1);
      chk("frz_relock_cnt", 32'(relock_cnt), 32'd2);
      freeze = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/dll_lock_ctrl.md
Name: dll_lock_ctrl

Overview:
Sequencer for the 10-bit SAR delay-line search plus the post-search tracking loop of the FMDLL. The block runs a binary search by pacing the SAR with settle/step timing and feeding it a filtered phase-detector decision. It then hands the SAR result to a filtered up/down tracking loop. It asserts lock, detects loss of lock, and restarts the search.

Parameters:
CODE_W, 10, delay-line code width; must match SAR Q width
SETTLE_CYC, 4, cycles waited after any code change before sampling the phase detector (min 1)
TRACK_AVG, 8, phase-detector samples accumulated per tracking decision (power of 2, ≥2)
LOCK_CNT, 3, consecutive "quiet" tracking updates required to assert locked
UNLOCK_RUN, 4, consecutive same-direction tracking steps that declare loss of lock

Ports:
clk4  in  1  controller clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; 0 forces IDLE
pd_lead  in  1  phase detector: feedback leads
pd_lag  in  1  phase detector: feedback lags
sar_q  in  CODE_W  current SAR code
sar_count  in  4  SAR bit pointer (9..0)
sar_rst_n  out  1  active-low reset to SAR
sar_step  out  1  one-cycle advance strobe to SAR
sar_comp  out  1  decision to SAR (1=lead, 0=lag)
dly_code  out  CODE_W  code driven to delay line
locked  out  1  lock indicator
relock_cnt  out  8  loss-of-lock events, saturating at 255
state  out  3  current FSM state, for debug

Behaviour:
- Reset values: sar_rst_n=0, sar_step=0, sar_comp=0, dly_code=10'h200, locked=0, relock_cnt=0, state=IDLE; internal counters and accumulator 0.
- PD decode: lead-only→+1/comp=1; lag-only→−1/comp=0; both or neither→0 and sar_comp holds its previous value.
- SAR contract: the SAR takes sar_step on the next clk4 edge. sar_q/sar_count are valid at the second posedge after sar_step.
- States:
  - IDLE: sar_rst_n=0, dly_code=10'h200. enable=1 → SAR_INIT.
  - SAR_INIT: sar_rst_n=1, load settle counter=SETTLE_CYC → SAR_SETTLE.
  - SAR_SETTLE: dly_code=sar_q; decrement settle counter; at 0 → SAR_STEP.
  - SAR_STEP: set sar_comp from PD, pulse sar_step for 1 cycle; latch last=(sar_count==0) → SAR_WAIT.
  - SAR_WAIT: 1 cycle. If last, capture trk_code=sar_q → TRK_SETTLE; else reload settle counter → SAR_SETTLE.
  - TRK_SETTLE: dly_code=trk_code; wait SETTLE_CYC cycles → TRK_ACC.
  - TRK_ACC: add PD value to signed accumulator each cycle for TRACK_AVG cycles → TRK_UPD.
  - TRK_UPD (1 cycle): acc ≥ TRACK_AVG/2 → trk_code+1; acc ≤ −TRACK_AVG/2 → trk_code−1; otherwise no step. Clear acc → TRK_SETTLE.
- Search latency: 10 steps × (SETTLE_CYC+2) cycles + 1 cycle (SAR_INIT).
- Lock rules, evaluated in TRK_UPD:
  - An update is "quiet" if there is no step, or the step direction reverses the previous step. Quiet updates increment the quiet counter and clear the run counter.
  - A same-direction step increments the run counter and clears the quiet counter.
  - Quiet counter reaching LOCK_CNT sets locked=1.
  - Run counter reaching UNLOCK_RUN → loss of lock.
- Saturation: a step beyond 0 or 1023 is suppressed and counts as loss of lock.
- Loss of lock: locked=0, relock_cnt+1 (saturating), lock/run/quiet counters cleared, sar_rst_n=0 for 1 cycle, then SAR_INIT.
- enable=0 in any state → IDLE on the next cycle. locked=0, no relock_cnt change; a sar_step already in flight completes but its result is discarded.
- Async reset mid-search returns to the reset values immediately.

Optional Feature:
DLL_TRACK_FREEZE_EN
- Defined: adds input port `freeze` (1 bit). While freeze=1 in TRK_* states, the accumulator is held at 0, TRK_UPD makes no step, and the lock/run/quiet counters and locked are held. Search states ignore freeze.
- Undefined: no port; tracking runs continuously.

Decomposition:
- Package dll_ctrl_pkg holds:
  - the state enum (IDLE, SAR_INIT, SAR_SETTLE, SAR_STEP, SAR_WAIT, TRK_SETTLE, TRK_ACC, TRK_UPD; 3 bits)
  - CODE_MID=10'h200
  - PD decode constants (+1/0/−1 encodings)
- One sub-module, dll_trk_filter: the accumulator, the decision logic, and the quiet/run counters. It outputs step_up, step_dn, quiet and lost.
- The FSM, the SAR interface and the code register stay in dll_lock_ctrl.

Test Plan:
- Reset, then enable=1 with a behavioural SAR and a PD model locking at code 0x2C5: exactly 10 sar_step pulses with sar_comp pattern 1,0,1,1,0,0,0,1,0,1; dly_code=0x2C5 entering TRK_SETTLE.
- In tracking, PD alternates lead/lag every TRACK_AVG window: after 3 TRK_UPD, locked=1 and dly_code stays within ±1 of 0x2C5.
- After lock, hold pd_lag=1 constantly: 4 consecutive −1 steps, then locked=0, relock_cnt=1, sar_rst_n low for 1 cycle, search restarts from 0x200.
- trk_code=1023 with pd_lead=1 constantly: no wrap to 0; loss of lock on the first suppressed step.
- enable drops during the 5th SAR step: IDLE next cycle, dly_code=0x200, locked=0, relock_cnt unchanged. Re-enable: a full 10-step search.
- With DLL_TRACK_FREEZE_EN, freeze=1 while locked and pd_lag=1 for 64 cycles: dly_code, locked and relock_cnt unchanged.
